sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3: number of requesting channels (2..8).
REQ-002 Parameter ADDR_W, default 18: SRAM address width.
REQ-003 Parameter DATA_W, default 16: SRAM data width.
REQ-004 Parameter WAIT_CYC, default 1: cycles in ACCESS state (1..15); 0 is illegal.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NUM_CH  per-channel access request, level, held until done.
REQ-008 wr  input  NUM_CH  per-channel op: 1 write, 0 read.
REQ-009 addr  input  NUM_CH*ADDR_W  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 wdata  input  NUM_CH*DATA_W  per-channel write data, same packing.
REQ-011 done  output  NUM_CH  one-cycle completion pulse to granted channel.
REQ-012 rdata  output  DATA_W  last read result, shared by all channels.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 sram_addr  output  ADDR_W  SRAM address.
REQ-015 sram_data  inout  DATA_W  SRAM data bus, tri-stated unless writing.
REQ-016 sram_en, sram_oe, sram_we  output  1 each  SRAM strobes, active-low.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS, FINISH; transitions IDLE->SETUP on grant, SETUP->ACCESS, ACCESS->FINISH after WAIT_CYC cycles, FINISH->IDLE.
REQ-018 In IDLE with any req bit high, arbiter SHALL grant exactly one channel and latch its wr, addr, wdata into internal registers.
REQ-019 IDLE: sram_en=1, sram_oe=1, sram_we=1, sram_data=Z, done=0.
REQ-020 SETUP: sram_en=0, sram_addr=latched addr; read: sram_oe=0; write: sram_data driven with latched wdata, sram_we=1.
REQ-021 ACCESS: read: sram_oe=0; write: sram_we=0, data held; internal counter counts WAIT_CYC cycles.
REQ-022 Read data SHALL be captured into rdata on the last ACCESS cycle edge; writes SHALL NOT alter rdata.
REQ-023 FINISH: sram_we=1, sram_oe=1, write data still driven (hold time), done[grant]=1 for exactly this cycle.
REQ-024 Latency from req sampled in IDLE to done pulse SHALL be 2+WAIT_CYC cycles; minimum spacing between grants 3+WAIT_CYC cycles.
REQ-025 Latched operands SHALL be used for the whole transaction; req/addr/wdata changes after grant are ignored; deasserting req mid-transaction still completes and pulses done.
REQ-026 Simultaneous requests: only one grant per transaction; losers wait in IDLE re-arbitration.
REQ-027 sram_data SHALL never be driven in IDLE or during reads.

Reset
REQ-028 rst low SHALL immediately force IDLE, all strobes 1, sram_data Z, done=0, busy=0, rdata=0, sram_addr=0, counter=0, RR pointer=NUM_CH-1.
REQ-029 Reset mid-transaction SHALL abandon it with no done pulse; operation resumes at first edge after rst rises.

Configuration
REQ-030 Macro SRAM_ARB_RR_EN defined: round-robin; search starts at last granted index+1, wrapping NUM_CH-1->0; pointer updates on grant.
REQ-031 Macro undefined: fixed priority, lowest index wins; no pointer register.

Verification
REQ-032 Single read, ch1, addr=0x00123, SRAM returns 0xBEEF, WAIT_CYC=1 -> done[1] exactly 3 cycles after grant, rdata=0xBEEF, sram_we never low.
REQ-033 Write ch0, addr=0x3FFFF, wdata=0xA5A5 -> sram_we low WAIT_CYC cycles, data driven SETUP..FINISH, rdata unchanged, done[0] pulse.
REQ-034 req=3'b111 held, RR enabled -> grant order 0,1,2,0; RR disabled -> ch0 granted every transaction.
REQ-035 rst low during ACCESS of write -> strobes high and sram_data Z same cycle, no done pulse, next grant proceeds normally.
REQ-036 ch2 read with req dropped after SETUP and addr changed to 0x00001 -> original address stays on sram_addr, done[2] still pulses.
REQ-037 WAIT_CYC=4, back-to-back reads ch0 then ch1 -> done pulses 7 cycles apart, busy low exactly one cycle between.

Source files
------------

// File: rtl/sram_arbiter.sv
// Arbitrates NUM_CH request channels onto one async SRAM port; SETUP/ACCESS/FINISH strobe sequencing.
// Latency: request seen in IDLE -> done pulse 2+WAIT_CYC cycles later; grants spaced 3+WAIT_CYC cycles.
// Backpressure: req is a level held until done; losing channels simply stay pending in IDLE.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration, otherwise fixed priority (lowest index wins).
module sram_arbiter #(
   parameter int NUM_CH   = 3,
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int WAIT_CYC = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        wr,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   output logic [NUM_CH-1:0]        done,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy,
   output logic [ADDR_W-1:0]        sram_addr,
   inout  wire  [DATA_W-1:0]        sram_data,
   output logic                     sram_en,
   output logic                     sram_oe,
   output logic                     sram_we
);

   localparam int IDX_W = $clog2(NUM_CH);
   localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               gnt_vld;
   logic [IDX_W-1:0]   gnt_sel;
   logic [IDX_W-1:0]   gnt_idx;
   logic               lat_wr;
   logic [DATA_W-1:0]  lat_wdata;
   logic [3:0]         cnt;
   logic               drv;

`ifdef SRAM_ARB_RR_EN
   logic [IDX_W-1:0]   rr_ptr;

   // Round-robin pick: scan from the channel after the last grant, nearest pending channel wins.
   always_comb begin
      int j;
      gnt_vld = 1'b0;
      gnt_sel = '0;
      j       = 0;
      for (int k = NUM_CH; k >= 1; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (req[j]) begin
            gnt_vld = 1'b1;
            gnt_sel = IDX_W'(j);
         end
      end
   end

   // Pointer remembers the last granted channel; it moves only when a grant is issued.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= IDX_W'(NUM_CH - 1);
      end else if (state == IDLE && gnt_vld) begin
         rr_ptr <= gnt_sel;
      end
   end
`else
   // Fixed priority pick: lowest pending index wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_sel = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (req[k]) begin
            gnt_vld = 1'b1;
            gnt_sel = IDX_W'(k);
         end
      end
   end
`endif

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand latch at grant, ACCESS wait counter, and read capture on the final ACCESS edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_idx   <= '0;
         lat_wr    <= 1'b0;
         lat_wdata <= '0;
         sram_addr <= '0;
         cnt       <= '0;
         rdata     <= '0;
      end else begin
         if (state == IDLE && gnt_vld) begin
            gnt_idx   <= gnt_sel;
            lat_wr    <= wr[gnt_sel];
            sram_addr <= addr[int'(gnt_sel)*ADDR_W +: ADDR_W];
            lat_wdata <= wdata[int'(gnt_sel)*DATA_W +: DATA_W];
         end
         if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
         end else begin
            cnt <= '0;
         end
         if (state == ACCESS && cnt == CNT_LAST && !lat_wr) begin
            rdata <= sram_data;
         end
      end
   end

   // Next-state and SRAM strobe decode; chip stays selected through FINISH so write data has hold time.
   always_comb begin
      state_nxt = state;
      sram_en   = 1'b1;
      sram_oe   = 1'b1;
      sram_we   = 1'b1;
      drv       = 1'b0;
      done      = '0;
      case (state)
         IDLE: begin
            if (gnt_vld) state_nxt = SETUP;
         end
         SETUP: begin
            sram_en   = 1'b0;
            sram_oe   = lat_wr;
            drv       = lat_wr;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            sram_en = 1'b0;
            sram_oe = lat_wr;
            sram_we = ~lat_wr;
            drv     = lat_wr;
            if (cnt == CNT_LAST) state_nxt = FINISH;
         end
         FINISH: begin
            sram_en        = 1'b0;
            drv            = lat_wr;
            done[gnt_idx]  = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign sram_data = drv ? lat_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one WAIT_CYC=1 three-channel instance and one WAIT_CYC=4 two-channel instance.
// Latency: each scenario walks cycle by cycle, sampling on the falling edge.
// Backpressure: the SRAM model drives the bus on reads and drives zero whenever the chip is deselected.
module tb_sram_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance (NUM_CH=3, WAIT_CYC=1)
   logic [2:0]  req, wr, done;
   logic [53:0] addr;
   logic [47:0] wdata;
   logic [15:0] rdata, rd_val;
   logic        busy, sram_en, sram_oe, sram_we;
   logic [17:0] sram_addr;
   wire  [15:0] sram_data;

   // Second instance (NUM_CH=2, WAIT_CYC=4)
   logic [1:0]  req4, wr4, done4;
   logic [35:0] addr4;
   logic [31:0] wdata4;
   logic [15:0] rdata4;
   logic        busy4, sram_en4, sram_oe4, sram_we4;
   logic [17:0] sram_addr4;
   wire  [15:0] sram_data4;

   int errors = 0;
   int checks = 0;

   // SRAM model: returns data on reads, parks the bus at zero when deselected so any stray DUT drive corrupts it.
   assign sram_data  = (sram_en || !sram_oe) ? (sram_oe ? 16'h0000 : rd_val) : 16'bz;
   assign sram_data4 = (sram_en4 || !sram_oe4) ? (sram_oe4 ? 16'h0000 : {sram_addr4[7:0], 8'h5A}) : 16'bz;

   sram_arbiter #(.NUM_CH(3), .ADDR_W(18), .DATA_W(16), .WAIT_CYC(1)) u_dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .done(done), .rdata(rdata), .busy(busy), .sram_addr(sram_addr),
      .sram_data(sram_data), .sram_en(sram_en), .sram_oe(sram_oe), .sram_we(sram_we));

   sram_arbiter #(.NUM_CH(2), .ADDR_W(18), .DATA_W(16), .WAIT_CYC(4)) u_dut4 (
      .clk(clk), .rst(rst), .req(req4), .wr(wr4), .addr(addr4), .wdata(wdata4),
      .done(done4), .rdata(rdata4), .busy(busy4), .sram_addr(sram_addr4),
      .sram_data(sram_data4), .sram_en(sram_en4), .sram_oe(sram_oe4), .sram_we(sram_we4));

   task automatic test_reset();
      req = '0; wr = '0; addr = '0; wdata = '0; rd_val = '0;
      req4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b0_111_000) begin
         errors++; $display("FAIL reset_strobes: got %b want %b", {busy, sram_en, sram_oe, sram_we, done}, 7'b0_111_000);
      end
      checks++;
      if (sram_addr !== 18'h0 || rdata !== 16'h0) begin
         errors++; $display("FAIL reset_addr_rdata: got %h/%h want 0/0", sram_addr, rdata);
      end
      checks++;
      if (sram_data !== 16'h0000) begin
         errors++; $display("FAIL reset_bus: got %h want 0000", sram_data);
      end
      checks++;
      if ({busy4, sram_en4, sram_oe4, sram_we4, done4, rdata4} !== {6'b0_111_00, 16'h0}) begin
         errors++; $display("FAIL reset_inst4: got %b want %b", {busy4, sram_en4, sram_oe4, sram_we4, done4, rdata4}, {6'b0_111_00, 16'h0});
      end
      rst = 1'b1;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      req[1] = 1'b1; wr[1] = 1'b0; addr[18 +: 18] = 18'h00123; wdata[16 +: 16] = 16'h1111; rd_val = 16'hBEEF;
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_001_000 || sram_addr !== 18'h00123) begin
         errors++; $display("FAIL read_setup: got %b addr %h want %b addr 00123", {busy, sram_en, sram_oe, sram_we, done}, sram_addr, 7'b1_001_000);
      end
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_001_000 || sram_data !== 16'hBEEF) begin
         errors++; $display("FAIL read_access: got %b bus %h want %b bus beef", {busy, sram_en, sram_oe, sram_we, done}, sram_data, 7'b1_001_000);
      end
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_011_010 || rdata !== 16'hBEEF) begin
         errors++; $display("FAIL read_finish: got %b rdata %h want %b rdata beef", {busy, sram_en, sram_oe, sram_we, done}, rdata, 7'b1_011_010);
      end
      req[1] = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b0_111_000 || sram_data !== 16'h0000) begin
         errors++; $display("FAIL read_idle: got %b bus %h want %b bus 0000", {busy, sram_en, sram_oe, sram_we, done}, sram_data, 7'b0_111_000);
      end
   endtask

   task automatic test_write();
      req[0] = 1'b1; wr[0] = 1'b1; addr[0 +: 18] = 18'h3FFFF; wdata[0 +: 16] = 16'hA5A5;
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_011_000 || sram_data !== 16'hA5A5 || sram_addr !== 18'h3FFFF) begin
         errors++; $display("FAIL write_setup: got %b bus %h addr %h want %b a5a5 3ffff", {busy, sram_en, sram_oe, sram_we, done}, sram_data, sram_addr, 7'b1_011_000);
      end
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_010_000 || sram_data !== 16'hA5A5) begin
         errors++; $display("FAIL write_access: got %b bus %h want %b a5a5", {busy, sram_en, sram_oe, sram_we, done}, sram_data, 7'b1_010_000);
      end
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_011_001 || sram_data !== 16'hA5A5 || rdata !== 16'hBEEF) begin
         errors++; $display("FAIL write_finish: got %b bus %h rdata %h want %b a5a5 beef", {busy, sram_en, sram_oe, sram_we, done}, sram_data, rdata, 7'b1_011_001);
      end
      req[0] = 1'b0; wr[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b0_111_000 || sram_data !== 16'h0000) begin
         errors++; $display("FAIL write_idle: got %b bus %h want %b 0000", {busy, sram_en, sram_oe, sram_we, done}, sram_data, 7'b0_111_000);
      end
   endtask

   task automatic test_arbitration();
      logic [2:0] exp_done [4];
      int pulses = 0;
      int last_cyc = 0;
`ifdef SRAM_ARB_RR_EN
      exp_done = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
      exp_done = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; req = 3'b111; wr = 3'b000;
      for (int cyc = 0; cyc < 40 && pulses < 4; cyc++) begin
         @(negedge clk);
         if (done !== 3'b000) begin
            checks++;
            if (done !== exp_done[pulses]) begin
               errors++; $display("FAIL arb_order%0d: got %b want %b", pulses, done, exp_done[pulses]);
            end
            if (pulses > 0) begin
               checks++;
               if (cyc - last_cyc !== 4) begin
                  errors++; $display("FAIL arb_spacing%0d: got %0d want 4", pulses, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            pulses++;
         end
      end
      req = 3'b000;
      checks++;
      if (pulses !== 4) begin
         errors++; $display("FAIL arb_timeout: got %0d pulses want 4", pulses);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      req[0] = 1'b1; wr[0] = 1'b1; addr[0 +: 18] = 18'h00055; wdata[0 +: 16] = 16'h5A5A;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_010_000) begin
         errors++; $display("FAIL rstw_access: got %b want %b", {busy, sram_en, sram_oe, sram_we, done}, 7'b1_010_000);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b0_111_000 || sram_data !== 16'h0000 || sram_addr !== 18'h0) begin
         errors++; $display("FAIL rstw_abort: got %b bus %h addr %h want %b 0000 0", {busy, sram_en, sram_oe, sram_we, done}, sram_data, sram_addr, 7'b0_111_000);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 4'b0_000) begin
         errors++; $display("FAIL rstw_hold: got %b want 0000", {busy, done});
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_011_000) begin
         errors++; $display("FAIL rstw_resume_setup: got %b want %b", {busy, sram_en, sram_oe, sram_we, done}, 7'b1_011_000);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_011_001 || sram_addr !== 18'h00055 || sram_data !== 16'h5A5A) begin
         errors++; $display("FAIL rstw_resume_done: got %b addr %h bus %h want %b 00055 5a5a", {busy, sram_en, sram_oe, sram_we, done}, sram_addr, sram_data, 7'b1_011_001);
      end
      req[0] = 1'b0; wr[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_req_drop();
      req[2] = 1'b1; wr[2] = 1'b0; addr[36 +: 18] = 18'h00456; wdata[32 +: 16] = 16'h0F0F; rd_val = 16'h1234;
      @(negedge clk);
      req[2] = 1'b0; addr[36 +: 18] = 18'h00001;
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_001_000 || sram_addr !== 18'h00456) begin
         errors++; $display("FAIL drop_access: got %b addr %h want %b 00456", {busy, sram_en, sram_oe, sram_we, done}, sram_addr, 7'b1_001_000);
      end
      @(negedge clk);
      checks++;
      if ({busy, sram_en, sram_oe, sram_we, done} !== 7'b1_011_100 || rdata !== 16'h1234 || sram_addr !== 18'h00456) begin
         errors++; $display("FAIL drop_finish: got %b rdata %h addr %h want %b 1234 00456", {busy, sram_en, sram_oe, sram_we, done}, rdata, sram_addr, 7'b1_011_100);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 4'b0_000) begin
         errors++; $display("FAIL drop_no_regrant: got %b want 0000", {busy, done});
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int t0 = 0;
      int idle_cnt = 0;
      req4 = 2'b11; wr4 = 2'b00; addr4 = {18'h00022, 18'h00011};
      for (int cyc = 0; cyc < 40 && pulses < 2; cyc++) begin
         @(negedge clk);
         if (pulses == 1 && !busy4) idle_cnt++;
         if (done4 !== 2'b00) begin
            if (pulses == 0) begin
               checks++;
               if (done4 !== 2'b01 || rdata4 !== 16'h115A || {busy4, sram_en4, sram_oe4, sram_we4} !== 4'b1011) begin
                  errors++; $display("FAIL b2b_first: got %b rdata %h strobes %b want 01 115a 1011", done4, rdata4, {busy4, sram_en4, sram_oe4, sram_we4});
               end
               t0 = cyc;
               req4[0] = 1'b0;
            end else begin
               checks++;
               if (done4 !== 2'b10 || rdata4 !== 16'h225A) begin
                  errors++; $display("FAIL b2b_second: got %b rdata %h want 10 225a", done4, rdata4);
               end
               checks++;
               if (cyc - t0 !== 7) begin
                  errors++; $display("FAIL b2b_spacing: got %0d want 7", cyc - t0);
               end
               checks++;
               if (idle_cnt !== 1) begin
                  errors++; $display("FAIL b2b_idle_gap: got %0d want 1", idle_cnt);
               end
               req4 = 2'b00;
            end
            pulses++;
         end
      end
      req4 = 2'b00;
      checks++;
      if (pulses !== 2) begin
         errors++; $display("FAIL b2b_timeout: got %0d pulses want 2", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_arbitration();
      test_reset_mid_write();
      test_req_drop();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
